// File: rtl/ovl_sched_pkg.sv
// Shared types and constants for the OVL fire scheduler and the checker bank
// that feeds it.
package ovl_sched_pkg;

  localparam int unsigned FIRE_W_DEF      = 3;
  localparam int unsigned FIRE_BIT_2STATE = 0;
  localparam int unsigned FIRE_BIT_XCHECK = 1;
  localparam int unsigned FIRE_BIT_COVER  = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/ovl_fire_scheduler_if.sv
// Report stream from the fire scheduler to the error logger / debug FIFO.
interface ovl_fire_scheduler_if
  import ovl_sched_pkg::*;
#(
  parameter int unsigned ID_W   = 2,
  parameter int unsigned FIRE_W = FIRE_W_DEF
);
  logic              rpt_valid;
  logic              rpt_ready;
  logic [ID_W-1:0]   rpt_id;
  logic [FIRE_W-1:0] rpt_fire;

  modport master (output rpt_valid, output rpt_id, output rpt_fire, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_id, input rpt_fire, output rpt_ready);
endinterface

// File: rtl/ovl_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around.
module ovl_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win_c,
  output logic          found_c
);

  int unsigned   idx;
  logic [IW-1:0] cand;

  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx  = (32'(ptr) + i) % N;
      cand = IW'(idx);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        win_c   = cand;
      end
    end
  end

endmodule

// File: rtl/ovl_fire_scheduler.sv
// Buffers per-checker OVL fire vectors, merges repeats while pending and
// serialises them round-robin onto a valid/ready report stream.
module ovl_fire_scheduler
  import ovl_sched_pkg::*;
#(
  parameter int unsigned NUM_CHK = 4,
  parameter int unsigned FIRE_W  = FIRE_W_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CHK*FIRE_W-1:0] fire_in,
  ovl_fire_scheduler_if.master      rpt,
  output logic [NUM_CHK-1:0]        pending,
  output logic [CNT_W-1:0]          merge_cnt
);

  localparam int unsigned ID_W    = $clog2(NUM_CHK);
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;
  localparam logic [0:0]  S_IDLE    = 1'(ST_IDLE);
  localparam logic [0:0]  S_PRESENT = 1'(ST_PRESENT);

  logic [0:0]                          state_q, state_d;
  logic [ID_W-1:0]                     ptr_q, ptr_d;
  logic [NUM_CHK-1:0][FIRE_W-1:0]      bits_q, bits_d;
  logic [NUM_CHK-1:0]                  pend_d;
  logic [CNT_W-1:0]                    cnt_d;
  logic                                valid_d;
  logic [ID_W-1:0]                     id_d;
  logic [FIRE_W-1:0]                   fire_d;
  logic [ID_W-1:0]                     win;
  logic                                found;
  logic                                load;
  logic [NUM_CHK-1:0]                  cap;
  int unsigned                         n_merge;
  int unsigned                         headroom;

  ovl_rr_pick #(.N(NUM_CHK), .IW(ID_W)) u_pick (
    .req     (pending),
    .ptr     (ptr_q),
    .win_c   (win),
    .found_c (found)
  );

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHK; c++) begin
      cap[c] = enable && (fire_in[c*FIRE_W +: FIRE_W] != '0);
    end
  end

  // Next state: load winner on idle or handshake, then apply new captures.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bits_d   = bits_q;
    pend_d   = pending;
    cnt_d    = merge_cnt;
    valid_d  = rpt.rpt_valid;
    id_d     = rpt.rpt_id;
    fire_d   = rpt.rpt_fire;
    load     = 1'b0;
    n_merge  = 0;
    headroom = 0;

    if (state_q == S_IDLE) begin
      load = found;
    end else if (rpt.rpt_ready) begin
      load = found;
      if (!found) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    end

    if (load) begin
      state_d      = S_PRESENT;
      valid_d      = 1'b1;
      id_d         = win;
      fire_d       = bits_q[win];
      ptr_d        = (win == ID_W'(NUM_CHK - 1)) ? '0 : win + ID_W'(1);
      pend_d[win]  = 1'b0;
      bits_d[win]  = '0;
    end

    // An entry cleared this cycle has pend_d low, so a racing fire starts fresh.
    for (int unsigned c = 0; c < NUM_CHK; c++) begin
      if (cap[c]) begin
        if (pend_d[c]) n_merge = n_merge + 1;
        pend_d[c] = 1'b1;
        bits_d[c] = bits_d[c] | fire_in[c*FIRE_W +: FIRE_W];
      end
    end

    headroom = CNT_MAX - 32'(merge_cnt);
    if (n_merge > headroom) cnt_d = '1;
    else                    cnt_d = merge_cnt + CNT_W'(n_merge);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      bits_q        <= '0;
      pending       <= '0;
      merge_cnt     <= '0;
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_id    <= '0;
      rpt.rpt_fire  <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      bits_q        <= bits_d;
      pending       <= pend_d;
      merge_cnt     <= cnt_d;
      rpt.rpt_valid <= valid_d;
      rpt.rpt_id    <= id_d;
      rpt.rpt_fire  <= fire_d;
    end
  end

endmodule

// File: tb/tb_ovl_fire_scheduler.sv
// Bench for ovl_fire_scheduler: directed vector table, a saturation sequence
// on a narrow-counter instance, then random traffic against a queue-level model.
module tb_ovl_fire_scheduler;
  import ovl_sched_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned FW  = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned CWS = 2;
  localparam int unsigned IW  = 2;
  localparam int unsigned FIW = N * FW;

  logic           clock = 1'b0;
  logic           reset;
  logic           enable;
  logic [FIW-1:0] fire_in;
  logic           ready;
  logic [N-1:0]   pending, pending_s;
  logic [CW-1:0]  merge_cnt;
  logic [CWS-1:0] merge_cnt_s;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  always #5 clock = ~clock;

  ovl_fire_scheduler_if #(.ID_W(IW), .FIRE_W(FW)) rpt_m ();
  ovl_fire_scheduler_if #(.ID_W(IW), .FIRE_W(FW)) rpt_s ();
  assign rpt_m.rpt_ready = ready;
  assign rpt_s.rpt_ready = ready;

  ovl_fire_scheduler #(.NUM_CHK(N), .FIRE_W(FW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in),
    .rpt(rpt_m), .pending(pending), .merge_cnt(merge_cnt)
  );

  ovl_fire_scheduler #(.NUM_CHK(N), .FIRE_W(FW), .CNT_W(CWS)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in),
    .rpt(rpt_s), .pending(pending_s), .merge_cnt(merge_cnt_s)
  );

  // Reference model: per-checker pending sets, a report slot and an
  // unbounded merge tally clipped on comparison.
  int mbits[N];
  bit mpend[N];
  int mptr, mid, mfire, mcnt;
  bit mvalid;

  task automatic model_step();
    int w;
    bit hs;
    int f;
    if (reset) begin
      foreach (mbits[c]) begin mbits[c] = 0; mpend[c] = 0; end
      mptr = 0; mid = 0; mfire = 0; mcnt = 0; mvalid = 0;
    end else begin
      hs = mvalid && ready;
      w  = -1;
      if (!mvalid || hs)
        for (int k = 0; k < N; k++)
          if (w < 0 && mpend[(mptr + k) % N]) w = (mptr + k) % N;
      if (w >= 0) begin
        mvalid = 1; mid = w; mfire = mbits[w];
        mbits[w] = 0; mpend[w] = 0; mptr = (w + 1) % N;
      end else if (hs) begin
        mvalid = 0;
      end
      if (enable)
        for (int c = 0; c < N; c++) begin
          f = int'(fire_in[c*FW +: FW]);
          if (f != 0) begin
            if (mpend[c]) mcnt++;
            mpend[c] = 1;
            mbits[c] |= f;
          end
        end
    end
  endtask

  function automatic int clip(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [FIW-1:0] f(int c, int b);
    logic [FIW-1:0] v;
    v = '0;
    v[c*FW +: FW] = FW'(b);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic check_model();
    int p;
    p = 0;
    for (int c = 0; c < N; c++) if (mpend[c]) p |= (1 << c);
    chk("model_valid", int'(rpt_m.rpt_valid), int'(mvalid));
    if (mvalid) begin
      chk("model_id", int'(rpt_m.rpt_id), mid);
      chk("model_fire", int'(rpt_m.rpt_fire), mfire);
    end
    chk("model_pending", int'(pending), p);
    chk("model_cnt", int'(merge_cnt), clip(mcnt, 255));
    chk("model_cnt_sat", int'(merge_cnt_s), clip(mcnt, 3));
    chk("model_valid_sat", int'(rpt_s.rpt_valid), int'(mvalid));
  endtask

  typedef struct {
    bit             rst, en, rdy;
    logic [FIW-1:0] fire;
    bit             ev;
    int             eid, efire, epend, ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit rst, bit en, bit rdy, logic [FIW-1:0] fi,
                     bit ev, int eid, int efire, int epend, int ecnt);
    tbl.push_back('{rst, en, rdy, fi, ev, eid, efire, epend, ecnt});
  endtask

  initial begin
    logic [FIW-1:0] rv;
    reset = 1'b1; enable = 1'b1; ready = 1'b1; fire_in = '0;

    // single fire latency
    add(1,1,1,'0,               0,0,0,4'b0000,0);
    add(0,1,1,f(2,1),           0,0,0,4'b0100,0);
    add(0,1,1,'0,               1,2,1,4'b0000,0);
    add(0,1,1,'0,               0,0,0,4'b0000,0);
    // round-robin, twice with pointer wrap
    add(1,1,1,'0,               0,0,0,4'b0000,0);
    for (int r = 0; r < 2; r++) begin
      add(0,1,1,f(0,1)|f(1,2)|f(3,4), 0,0,0,4'b1011,0);
      add(0,1,1,'0,             1,0,1,4'b1010,0);
      add(0,1,1,'0,             1,1,2,4'b1000,0);
      add(0,1,1,'0,             1,3,4,4'b0000,0);
      add(0,1,1,'0,             0,0,0,4'b0000,0);
    end
    // backpressure and merge
    add(0,1,0,f(0,1),           0,0,0,4'b0001,0);
    add(0,1,0,f(1,1),           1,0,1,4'b0010,0);
    add(0,1,0,f(1,2),           1,0,1,4'b0010,1);
    add(0,1,0,'0,               1,0,1,4'b0010,1);
    add(0,1,1,'0,               1,1,3,4'b0000,1);
    add(0,1,1,'0,               0,0,0,4'b0000,1);
    // clear/capture race
    add(0,1,1,f(2,1),           0,0,0,4'b0100,1);
    add(0,1,1,f(2,4),           1,2,1,4'b0100,1);
    add(0,1,1,'0,               1,2,4,4'b0000,1);
    add(0,1,1,'0,               0,0,0,4'b0000,1);
    // enable low
    add(0,0,1,'1,               0,0,0,4'b0000,1);
    add(0,0,1,'1,               0,0,0,4'b0000,1);
    // reset during PRESENT, with ready high in the reset cycle
    add(0,1,0,f(1,1),           0,0,0,4'b0010,1);
    add(0,1,0,'0,               1,1,1,4'b0000,1);
    add(0,1,0,f(3,2),           1,1,1,4'b1000,1);
    add(1,1,1,f(3,1),           0,0,0,4'b0000,0);
    add(0,1,1,'0,               0,0,0,4'b0000,0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; enable = tbl[i].en; ready = tbl[i].rdy; fire_in = tbl[i].fire;
      cycle();
      chk("tbl_valid", int'(rpt_m.rpt_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_id", int'(rpt_m.rpt_id), tbl[i].eid);
        chk("tbl_fire", int'(rpt_m.rpt_fire), tbl[i].efire);
      end
      chk("tbl_pending", int'(pending), tbl[i].epend);
      chk("tbl_cnt", int'(merge_cnt), tbl[i].ecnt);
      chk("tbl_cnt_sat", int'(merge_cnt_s), clip(tbl[i].ecnt, 3));
    end

    // saturation: checker 0 held in PRESENT while checker 1 merges repeatedly
    reset = 0; enable = 1; ready = 0;
    fire_in = f(0,1); cycle();
    fire_in = f(1,1); cycle();
    for (int k = 1; k <= 9; k++) begin
      fire_in = f(1, 1 << (k % 3));
      cycle();
      chk("sat_cnt_wide", int'(merge_cnt), k);
      chk("sat_cnt_narrow", int'(merge_cnt_s), clip(k, 3));
      chk("sat_hold_id", int'(rpt_m.rpt_id), 0);
      chk("sat_hold_fire", int'(rpt_m.rpt_fire), 1);
    end
    fire_in = '0; ready = 1; cycle();
    chk("sat_release_id", int'(rpt_m.rpt_id), 1);
    chk("sat_release_fire", int'(rpt_m.rpt_fire), 7);
    chk("sat_release_cnt", int'(merge_cnt_s), 3);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(99) == 0);
      enable = ($urandom_range(9) != 0);
      ready  = ($urandom_range(9) < 6);
      rv = '0;
      for (int c = 0; c < N; c++)
        if ($urandom_range(3) == 0) rv[c*FW +: FW] = FW'($urandom_range(7));
      fire_in = rv;
      cycle();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ovl_fire_scheduler.md
# ovl_fire_scheduler

Collects the 3-bit `fire` vectors from up to NUM_CHK OVL checkers (ovl_range and siblings) and serialises them into a single report stream over a valid/ready handshake. Fires are buffered per checker, bit-merged while pending, and granted round-robin. Sits between the assertion checker bank and the on-chip error logger or debug FIFO.

## Interface
- NUM_CHK, 4, number of checker fire inputs (2..16)
- FIRE_W, 3, fire vector width per checker (bit0 2-state, bit1 xcheck, bit2 cover)
- CNT_W, 8, width of the saturating merge counter
- ID_W, $clog2(NUM_CHK), report id width (derived)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  gates capture of new fires; arbitration and reporting continue when low
- fire_in  in  NUM_CHK*FIRE_W  checker c occupies bits [c*FIRE_W +: FIRE_W]
- rpt_ready  in  1  consumer accepts report
- rpt_valid  out  1  report present
- rpt_id  out  ID_W  index of reported checker
- rpt_fire  out  FIRE_W  merged fire bits of reported checker
- pending  out  NUM_CHK  per-checker pending flag
- merge_cnt  out  CNT_W  fires merged into an already pending entry, saturating

## Operation
- Capture: when enable=1 and fire_in for checker c is nonzero, pend_bits[c] |= fire_in[c]; pending[c] is set.
- Merge: a nonzero capture into an entry that is already pending and not being cleared in the same cycle increments merge_cnt by one per checker per cycle. The counter saturates at 2^CNT_W-1 and never wraps.
- FSM states:
  - IDLE to PRESENT when any pending bit is set. The winner is loaded into the report registers and its entry is cleared.
  - PRESENT holds while rpt_valid & !rpt_ready.
  - On handshake, PRESENT loads the next winner if any entry is pending; otherwise it returns to IDLE.
- Arbitration: round-robin over pending. The search starts at ptr; the first pending index at or above ptr, wrapping, wins. ptr becomes winner+1 mod NUM_CHK on each load.
- Simultaneous events: a fire on checker c in the same cycle its entry is loaded sets a fresh pending entry with only the new bits. No merge is counted and the bits are not added to the current report.
- rpt_id and rpt_fire stay stable while rpt_valid & !rpt_ready.
- Reset mid-report drops the report, all pending entries and the counter.

## Timing
- Reset values:
  - rpt_valid=0, rpt_id=0, rpt_fire=0
  - pending=0, merge_cnt=0
  - ptr=0, state IDLE
- Latency: fire_in nonzero in cycle t gives pending in cycle t+1 and rpt_valid in cycle t+2, when idle.
- Throughput: one report per cycle while rpt_ready=1 and entries are pending. rpt_valid does not drop between back-to-back reports.
- All outputs are registered. There is no combinational path from fire_in or rpt_ready to any output.
- rpt_valid=1 with rpt_ready=1 in the reset cycle is not a handshake.

## Structure
- Package ovl_sched_pkg holds:
  - the state enum (IDLE, PRESENT)
  - the FIRE_W default and the fire bit-position constants, shared with the checker bank
- One sub-module, ovl_rr_pick. It is combinational: inputs are the pending vector and ptr; outputs are the winner index and a found flag. It is reusable by other schedulers.

## Test plan
- Single fire, NUM_CHK=4, rpt_ready=1. Stimulus: fire_in[2]=3'b001 in cycle 0. Response: rpt_valid in cycle 2 with rpt_id=2, rpt_fire=001; pending=0 in cycle 3.
- Round-robin. Stimulus: checkers 0, 1 and 3 fire in the same cycle, rpt_ready=1. Response: ids 0, 1, 3 on consecutive cycles. A repeat of all three then yields 0, 1, 3 again, with ptr wrapping from 0.
- Backpressure and merge. Stimulus: rpt_ready=0; checker 1 fires 001, then 010 while checker 0 is held in PRESENT. Response: the report for checker 0 stays stable; checker 1 is reported later with fire 011; merge_cnt=1.
- Clear/capture race. Stimulus: checker 2 fires in the same cycle its entry is loaded. Response: a second report for checker 2 carries only the new bits; merge_cnt is unchanged.
- Saturation. Stimulus: CNT_W=2, six merged fires. Response: merge_cnt=3 and holds.
- enable=0 and reset. Stimulus: fires while enable=0. Response: no reports. Stimulus: reset asserted during PRESENT. Response: next cycle rpt_valid=0, pending=0, merge_cnt=0.
